adder_share_arb: RTL
====================

# adder_share_arb

Round-robin arbiter that shares one pipelined W-bit adder between N requesters. It accepts one add request per cycle, drives the adder's start/operand inputs, and tracks each issued operation through the adder's fixed latency. It returns every sum to its requester with the originating ID, and allows at most one outstanding operation per requester. It sits between the requesting engines and the shared adder, and is the only block that drives the adder's inputs.

## Interface
- W, 10, operand/result width; must match the shared adder.
- N, 4, number of requesters, 2..8.
- LAT, 2, adder latency: cycles from adder start high to adder sum valid.
- IDW, derived, ID width = max(1, ceil(log2 N)); not overridable.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request; held with operands until the matching ack.
- op_a  in  N*W  operand A; requester i uses bits [i*W +: W].
- op_b  in  N*W  operand B, same packing as op_a.
- hold  in  1  suspends new grants while high.
- ack  out  N  one-hot, combinational; request accepted this cycle.
- busy  out  N  registered; requester i has an operation in flight.
- add_start  out  1  registered start pulse to the adder.
- add_a, add_b  out  W  registered operands to the adder.
- add_y  in  W  adder sum.
- rsp_valid  out  1  registered; response valid for one cycle.
- rsp_id  out  IDW  requester index of the response.
- rsp_data  out  W  sum returned to the requester.

## Operation
- Eligibility:
  - elig[i] = req[i] & ~busy[i].
  - No grant when hold=1 or no requester is eligible.
- Arbitration:
  - Round-robin pointer ptr holds the last granted index; reset value is N-1, so requester 0 wins first.
  - Search order is ptr+1, ptr+2, … modulo N.
  - The first eligible index g wins: ack[g]=1 and ptr <= g.
  - At most one ack per cycle.
  - ack is a function of req, busy, hold and ptr only, never of op_a/op_b.
- Issue, on the clock edge ending an ack cycle:
  - add_start<=1, add_a<=op_a[g], add_b<=op_b[g], busy[g]<=1.
  - Otherwise add_start<=0; add_a/add_b hold their values.
- Tracking:
  - A LAT+1-stage shift register carries (valid, id).
  - Stage 0 loads (add_start_next, g).
  - When the last stage is valid, rsp_valid<=1, rsp_id<=id, rsp_data<=add_y, and busy[id]<=0 on that same edge.
  - Otherwise rsp_valid<=0; rsp_id and rsp_data hold their values.
- Arithmetic: the sum is add_a+add_b modulo 2^W, computed by the adder. No carry out is returned, and overflow wraps silently.
- hold:
  - Affects only new grants.
  - In-flight operations complete and respond normally.
  - Deasserting hold allows a grant in that same cycle.
- Requester protocol:
  - After ack, req may drop or stay high.
  - The requester is masked until its response.
  - Dropping req before ack withdraws the request with no side effects.
- Reset: an asynchronous clear of all state. In-flight operations are discarded and no response is emitted for them.
  - ack=0, busy=0, add_start=0, add_a=add_b=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - ptr=N-1, shift register empty.

## Timing
- Ack in cycle t gives:
  - add_start=1 in cycle t+1;
  - sum present on add_y in cycle t+1+LAT;
  - rsp_valid=1 in cycle t+2+LAT (t+4 for LAT=2).
- Throughput is one issue per cycle across distinct requesters.
- busy[i] is high from cycle t+1 through cycle t+1+LAT. It is low in the rsp_valid cycle, so requester i may be re-granted in its own response cycle.
- Back-to-back issues give back-to-back responses in issue order, one per cycle.
- Issue and response on the same edge for the same requester: the clear from the response and the set from the new grant cannot collide, because a busy requester is never eligible.
- rsp_valid is never high for more than one cycle per issued operation.

## Test plan
- Single request, idle block:
  - Stimulus: reset, then req=0001 with op_a[0]=3, op_b[0]=5 at cycle 0.
  - Required: ack=0001 at cycle 0; add_start at cycle 1 with add_a=3, add_b=5; rsp_valid at cycle 4 with rsp_id=0, rsp_data=8; busy[0] high in cycles 1..3.
- All four requesting continuously, op_a[i]=i, op_b[i]=10:
  - Required grant order 0,1,2,3 on consecutive cycles.
  - Responses (0,10),(1,11),(2,12),(3,13) on consecutive cycles starting at cycle 4.
  - Requester 0 re-granted at cycle 4.
- Wrap-around: op_a=1023, op_b=2 with W=10 -> rsp_data=1, no other flag.
- hold:
  - Stimulus: hold=1 for cycles 0..2 with req=0110.
  - Required: no ack and add_start=0 throughout; after hold drops at cycle 3, ack=0010 at cycle 3 and ack=0100 at cycle 4.
  - An operation issued before hold still responds on time.
- Fairness: requester 1 requests continuously and requester 2 requests from cycle 1. Requester 2 must be granted before any second grant to requester 1.
- Reset mid-flight: assert rst_n=0 one cycle after an ack. All outputs drop to reset values immediately, and no rsp_valid appears for the lost operation after reset is released.

Source files
------------

// File: rtl/adder_share_arb_if.sv
// Bundle of requester, shared-adder and response signals around adder_share_arb.
// The slave side is the arbiter. The master side is its environment: the requesters plus the adder.
interface adder_share_arb_if #(
  parameter int N = 4,
  parameter int W = 10
);
  localparam int IDW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic           hold;
  logic [N-1:0]   ack;
  logic [N-1:0]   busy;
  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;

  modport master (
    output req, op_a, op_b, hold, add_y,
    input  ack, busy, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, op_a, op_b, hold, add_y,
    output ack, busy, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one pipelined adder between N requesters.
// It tracks each issued operation through the adder latency and returns each sum with its requester ID.
module adder_share_arb #(
  parameter int W   = 10,
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input logic           clk,
  input logic           rst_n,
  adder_share_arb_if.slave bus
);
  localparam int IDW = (N > 2) ? $clog2(N) : 1;

  logic [IDW-1:0] ptr;
  logic [N-1:0]   elig;
  logic [N-1:0]   grant_oh;
  logic [N-1:0]   clr_oh;
  logic           found;
  logic [IDW-1:0] gid;
  logic [LAT:0]   vld_p;
  logic [IDW-1:0] id_p [LAT+1];

  // Returns {found, index} of the first eligible requester after p, wrapping modulo N.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] e, input logic [IDW-1:0] p);
    logic [IDW:0] r;
    int idx;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(p) + k) % N;
      if (!r[IDW] && e[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  // Grant stage: ack depends only on req, busy, hold and ptr; it is forced low while in reset.
  assign elig         = bus.req & ~bus.busy & {N{~bus.hold}};
  assign {found, gid} = rst_n ? rr_pick(elig, ptr) : '0;
  assign grant_oh     = found ? (N'(1) << gid) : '0;
  assign bus.ack      = grant_oh;
  assign clr_oh       = vld_p[LAT] ? (N'(1) << id_p[LAT]) : '0;

  // Issue stage and tracking pipeline: stage 0 is aligned with add_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= IDW'(N - 1);
      bus.busy      <= '0;
      bus.add_start <= 1'b0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      vld_p         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.add_start <= found;
      if (found) begin
        bus.add_a <= bus.op_a[int'(gid)*W +: W];
        bus.add_b <= bus.op_b[int'(gid)*W +: W];
        ptr       <= gid;
      end
      vld_p <= {vld_p[LAT-1:0], found};
      // A busy requester is never granted, so the set and clear masks never overlap.
      bus.busy      <= (bus.busy | grant_oh) & ~clr_oh;
      bus.rsp_valid <= vld_p[LAT];
      if (vld_p[LAT]) begin
        bus.rsp_id   <= id_p[LAT];
        bus.rsp_data <= bus.add_y;
      end
    end
  end

  // ID pipeline: its content matters only where the matching vld_p bit is set.
  always_ff @(posedge clk) begin
    id_p[0] <= gid;
    for (int s = 1; s <= LAT; s++) id_p[s] <= id_p[s-1];
  end
endmodule
